// File: rtl/bht_write_arbiter.sv
// Single write port arbiter for the BHT: ID allocations, EXE counter updates
// (with a small pending FIFO and stale-entry cancel) and an invalidation sweep.
module bht_write_arbiter #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned ENTRY_W = 20,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic                         CLK,
  input  logic                         nrst,
  input  logic                         en,
  input  logic                         id_req,
  input  logic [$clog2(ENTRIES)-1:0]   id_addr,
  input  logic [ENTRY_W-1:0]           id_data,
  input  logic                         exe_req,
  input  logic [$clog2(ENTRIES)-1:0]   exe_addr,
  input  logic [ENTRY_W-1:0]           exe_data,
  input  logic                         inv_start,
  output logic                         inv_busy,
  output logic                         inv_done,
  output logic                         wr_en,
  output logic [$clog2(ENTRIES)-1:0]   wr_addr,
  output logic [ENTRY_W-1:0]           wr_data,
  output logic                         exe_drop,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int unsigned AW   = $clog2(ENTRIES);
  localparam int unsigned CW   = $clog2(QDEPTH + 1);
  localparam int unsigned CNTW = AW + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [0:0]         state;
  logic [CNTW-1:0]    cnt;
  logic [AW-1:0]      q_addr [QDEPTH];
  logic [ENTRY_W-1:0] q_data [QDEPTH];

  logic [QDEPTH-1:0]  surv;
  logic [AW-1:0]      k_addr [QDEPTH];
  logic [ENTRY_W-1:0] k_data [QDEPTH];
  logic [CW-1:0]      k_cnt;
  logic [AW-1:0]      n_addr [QDEPTH];
  logic [ENTRY_W-1:0] n_data [QDEPTH];
  logic [CW-1:0]      n_cnt;
  logic               pop;
  logic               push;
  logic               drop;
  logic               w_en;
  logic [AW-1:0]      w_addr;
  logic [ENTRY_W-1:0] w_data;

  always_comb begin
    surv   = '0;
    k_addr = '{default: '0};
    k_data = '{default: '0};
    k_cnt  = '0;
    // Cancel queued entries whose slot is being reallocated, then compact the
    // survivors to the head so pop/push stay simple shifts.
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      surv[i] = (CW'(i) < q_count) && !(id_req && (q_addr[i] == id_addr));
      if (surv[i]) begin
        for (int unsigned j = 0; j < QDEPTH; j++) begin
          if (CW'(j) == k_cnt) begin
            k_addr[j] = q_addr[i];
            k_data[j] = q_data[i];
          end
        end
        k_cnt = k_cnt + CW'(1);
      end
    end

    pop    = !id_req && (k_cnt != '0);
    n_addr = k_addr;
    n_data = k_data;
    n_cnt  = k_cnt;
    if (pop) begin
      for (int unsigned j = 0; j < QDEPTH - 1; j++) begin
        n_addr[j] = k_addr[j+1];
        n_data[j] = k_data[j+1];
      end
      n_addr[QDEPTH-1] = '0;
      n_data[QDEPTH-1] = '0;
      n_cnt = k_cnt - CW'(1);
    end

    push = exe_req && (id_req || pop) && (n_cnt != CW'(QDEPTH));
    drop = exe_req && id_req && (n_cnt == CW'(QDEPTH));
    if (push) begin
      for (int unsigned j = 0; j < QDEPTH; j++) begin
        if (CW'(j) == n_cnt) begin
          n_addr[j] = exe_addr;
          n_data[j] = exe_data;
        end
      end
      n_cnt = n_cnt + CW'(1);
    end

    w_en   = 1'b0;
    w_addr = '0;
    w_data = '0;
    if (id_req) begin
      w_en   = 1'b1;
      w_addr = id_addr;
      w_data = id_data;
    end else if (pop) begin
      w_en   = 1'b1;
      w_addr = k_addr[0];
      w_data = k_data[0];
    end else if (exe_req) begin
      w_en   = 1'b1;
      w_addr = exe_addr;
      w_data = exe_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= '0;
      q_addr   <= '{default: '0};
      q_data   <= '{default: '0};
      q_count  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      inv_busy <= 1'b0;
      inv_done <= 1'b0;
      exe_drop <= 1'b0;
    end else if (!en) begin
      wr_en    <= 1'b0;
      exe_drop <= 1'b0;
      inv_done <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      exe_drop <= 1'b0;
      inv_done <= 1'b0;
      case (state)
        IDLE: begin
          if (inv_start) begin
            state    <= SWEEP;
            inv_busy <= 1'b1;
            cnt      <= '0;
            q_count  <= '0;
          end else begin
            q_addr   <= n_addr;
            q_data   <= n_data;
            q_count  <= n_cnt;
            exe_drop <= drop;
            if (w_en) begin
              wr_en   <= 1'b1;
              wr_addr <= w_addr;
              wr_data <= w_data;
            end
          end
        end
        SWEEP: begin
          // Extra cycle after the last write keeps inv_busy high over every sweep write.
          if (cnt == CNTW'(ENTRIES)) begin
            state    <= IDLE;
            inv_busy <= 1'b0;
            inv_done <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= cnt[AW-1:0];
            wr_data <= '0;
            cnt     <= cnt + CNTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bht_write_arbiter.sv
// Scenario-based bench for bht_write_arbiter with a queue-based reference model
// driving randomized traffic.
module tb_bht_write_arbiter;

  localparam int QD = 2;

  logic        CLK = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b1;
  logic        id_req = 1'b0;
  logic [5:0]  id_addr = '0;
  logic [19:0] id_data = '0;
  logic        exe_req = 1'b0;
  logic [5:0]  exe_addr = '0;
  logic [19:0] exe_data = '0;
  logic        inv_start = 1'b0;
  logic        inv_busy, inv_done, wr_en, exe_drop;
  logic [5:0]  wr_addr;
  logic [19:0] wr_data;
  logic [1:0]  q_count;

  int checks = 0;
  int errors = 0;

  bht_write_arbiter #(.ENTRIES(64), .ENTRY_W(20), .QDEPTH(QD)) dut (
    .CLK(CLK), .nrst(nrst), .en(en),
    .id_req(id_req), .id_addr(id_addr), .id_data(id_data),
    .exe_req(exe_req), .exe_addr(exe_addr), .exe_data(exe_data),
    .inv_start(inv_start), .inv_busy(inv_busy), .inv_done(inv_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .exe_drop(exe_drop), .q_count(q_count)
  );

  always #5 CLK = ~CLK;

  // Reference model: pending EXE updates as a queue, sweep as a position.
  typedef struct packed { logic [5:0] a; logic [19:0] d; } ent_t;
  ent_t        mq[$];
  int          m_pos = -1;
  logic        e_wr_en, e_drop, e_done, e_busy;
  logic [5:0]  e_wr_addr;
  logic [19:0] e_wr_data;

  task automatic model_edge();
    ent_t h;
    if (!nrst) begin
      mq.delete(); m_pos = -1;
      e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0;
      e_drop = 0; e_done = 0; e_busy = 0;
      return;
    end
    e_wr_en = 0; e_drop = 0; e_done = 0;
    if (!en) return;
    if (m_pos >= 0) begin
      if (m_pos == 64) begin
        m_pos = -1; e_busy = 0; e_done = 1;
      end else begin
        e_wr_en = 1; e_wr_addr = 6'(m_pos); e_wr_data = 0; m_pos++;
      end
    end else if (inv_start) begin
      mq.delete(); m_pos = 0; e_busy = 1;
    end else if (id_req) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].a == id_addr) mq.delete(i);
      e_wr_en = 1; e_wr_addr = id_addr; e_wr_data = id_data;
      if (exe_req) begin
        if (mq.size() < QD) mq.push_back('{a: exe_addr, d: exe_data});
        else e_drop = 1;
      end
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      e_wr_en = 1; e_wr_addr = h.a; e_wr_data = h.d;
      if (exe_req) mq.push_back('{a: exe_addr, d: exe_data});
    end else if (exe_req) begin
      e_wr_en = 1; e_wr_addr = exe_addr; e_wr_data = exe_data;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic clr_in();
    id_req = 0; exe_req = 0; inv_start = 0;
  endtask

  task automatic do_reset();
    clr_in(); nrst = 0; en = 1;
    tick(); tick();
    nrst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wr_en, wr_addr, wr_data} !== 27'd0) begin
      errors++; $display("FAIL reset_wr got %0h want 0", {wr_en, wr_addr, wr_data});
    end
    checks++;
    if ({inv_busy, inv_done, exe_drop, q_count} !== 5'd0) begin
      errors++; $display("FAIL reset_flags got %0b want 0", {inv_busy, inv_done, exe_drop, q_count});
    end
    tick();
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en got %0b want 0", wr_en); end
  endtask

  task automatic test_single_exe();
    exe_req = 1; exe_addr = 6'h05; exe_data = 20'h8A0F1;
    tick(); clr_in();
    checks++;
    if ({wr_en, wr_addr, wr_data, q_count} !== {1'b1, 6'h05, 20'h8A0F1, 2'd0}) begin
      errors++; $display("FAIL single_exe got %0b %0h %0h q%0d want 1 05 8a0f1 q0", wr_en, wr_addr, wr_data, q_count);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL single_exe_oneshot got %0b want 0", wr_en); end
  endtask

  task automatic test_collision();
    id_req = 1; id_addr = 6'h10; id_data = 20'h11111;
    exe_req = 1; exe_addr = 6'h21; exe_data = 20'h22222;
    tick(); clr_in();
    checks++;
    if ({wr_en, wr_addr, wr_data, q_count} !== {1'b1, 6'h10, 20'h11111, 2'd1}) begin
      errors++; $display("FAIL collide_id got %0b %0h %0h q%0d want 1 10 11111 q1", wr_en, wr_addr, wr_data, q_count);
    end
    tick();
    checks++;
    if ({wr_en, wr_addr, wr_data, q_count} !== {1'b1, 6'h21, 20'h22222, 2'd0}) begin
      errors++; $display("FAIL collide_exe got %0b %0h %0h q%0d want 1 21 22222 q0", wr_en, wr_addr, wr_data, q_count);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL collide_idle got %0b want 0", wr_en); end
  endtask

  task automatic test_overflow();
    int drops = 0;
    for (int k = 0; k < 3; k++) begin
      id_req = 1; id_addr = 6'(6'h30 + k); id_data = 20'(20'hA0000 + k);
      exe_req = 1; exe_addr = 6'(6'h01 + k); exe_data = 20'(20'hE0000 + k);
      tick();
      drops += int'(exe_drop);
      checks++;
      if ({wr_addr, q_count} !== {6'(6'h30 + k), 2'(k == 0 ? 1 : 2)}) begin
        errors++; $display("FAIL overflow_fill%0d got %0h q%0d want %0h q%0d", k, wr_addr, q_count, 6'h30 + k, k == 0 ? 1 : 2);
      end
    end
    clr_in();
    checks++;
    if (exe_drop !== 1'b1) begin errors++; $display("FAIL overflow_drop got %0b want 1", exe_drop); end
    for (int k = 0; k < 2; k++) begin
      tick();
      drops += int'(exe_drop);
      checks++;
      if ({wr_en, wr_addr, wr_data, q_count} !== {1'b1, 6'(6'h01 + k), 20'(20'hE0000 + k), 2'(1 - k)}) begin
        errors++; $display("FAIL overflow_drain%0d got %0b %0h %0h q%0d want 1 %0h %0h q%0d",
                           k, wr_en, wr_addr, wr_data, q_count, 6'h01 + k, 20'hE0000 + k, 1 - k);
      end
    end
    tick();
    checks++;
    if (drops != 1 || wr_en !== 1'b0) begin
      errors++; $display("FAIL overflow_end drops %0d wr_en %0b want 1 0", drops, wr_en);
    end
  endtask

  task automatic test_cancel();
    int bad = 0;
    id_req = 1; id_addr = 6'h3F; id_data = 20'h12345;
    exe_req = 1; exe_addr = 6'h0C; exe_data = 20'hCCCCC;
    tick();
    checks++;
    if (q_count !== 2'd1) begin errors++; $display("FAIL cancel_queued got q%0d want q1", q_count); end
    exe_req = 0; id_addr = 6'h0C; id_data = 20'h0BEEF;
    tick(); clr_in();
    checks++;
    if ({wr_en, wr_addr, wr_data, q_count, exe_drop} !== {1'b1, 6'h0C, 20'h0BEEF, 2'd0, 1'b0}) begin
      errors++; $display("FAIL cancel_id got %0b %0h %0h q%0d d%0b want 1 0c 0beef q0 d0",
                         wr_en, wr_addr, wr_data, q_count, exe_drop);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (wr_en !== 1'b0 || exe_drop !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL cancel_stale got %0d late writes/drops want 0", bad); end
  endtask

  task automatic test_sweep();
    int bad = 0;
    id_req = 1; id_addr = 6'h2A; id_data = 20'h00001;
    exe_req = 1; exe_addr = 6'h2B; exe_data = 20'h00002;
    tick();
    inv_start = 1; id_addr = 6'h11; exe_addr = 6'h12;
    tick();
    checks++;
    if ({wr_en, inv_busy, q_count} !== {1'b0, 1'b1, 2'd0}) begin
      errors++; $display("FAIL sweep_start got wr%0b busy%0b q%0d want wr0 busy1 q0", wr_en, inv_busy, q_count);
    end
    for (int k = 0; k < 64; k++) begin
      id_req = 1'($urandom); exe_req = 1'($urandom); inv_start = 1'($urandom);
      id_addr = 6'($urandom); exe_addr = 6'($urandom);
      tick();
      if ({wr_en, wr_addr, wr_data, inv_busy, exe_drop, inv_done, q_count} !==
          {1'b1, 6'(k), 20'd0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
        bad++;
        if (bad < 4) $display("FAIL sweep_write%0d got %0b %0h %0h busy%0b want 1 %0h 0 busy1", k, wr_en, wr_addr, wr_data, inv_busy, k);
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sweep_writes got %0d bad cycles want 0", bad); end
    clr_in();
    tick();
    checks++;
    if ({inv_done, inv_busy, wr_en} !== 3'b100) begin
      errors++; $display("FAIL sweep_done got %03b want 100", {inv_done, inv_busy, wr_en});
    end
    tick();
    checks++;
    if ({inv_done, wr_en, q_count} !== 4'b0) begin
      errors++; $display("FAIL sweep_after got %04b want 0000", {inv_done, wr_en, q_count});
    end
  endtask

  task automatic test_en_gating_reset();
    int bad = 0;
    inv_start = 1;
    tick(); clr_in();
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if ({wr_en, wr_addr} !== {1'b1, 6'd9}) begin
      errors++; $display("FAIL gate_pre got %0b %0h want 1 09", wr_en, wr_addr);
    end
    en = 0; id_req = 1; id_addr = 6'h05;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (wr_en !== 1'b0 || inv_busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL gate_hold got %0d bad cycles want 0", bad); end
    en = 1; id_req = 0;
    tick();
    checks++;
    if ({wr_en, wr_addr} !== {1'b1, 6'd10}) begin
      errors++; $display("FAIL gate_resume got %0b %0h want 1 0a", wr_en, wr_addr);
    end
    nrst = 0;
    tick();
    checks++;
    if ({inv_busy, inv_done, wr_en} !== 3'b000) begin
      errors++; $display("FAIL sweep_reset got %03b want 000", {inv_busy, inv_done, wr_en});
    end
    nrst = 1; bad = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (inv_done !== 1'b0 || wr_en !== 1'b0 || inv_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sweep_abort got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_random();
    bit hit;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      en        = ($urandom_range(0, 99) < 92);
      id_req    = ($urandom_range(0, 99) < 35);
      exe_req   = ($urandom_range(0, 99) < 55);
      inv_start = ($urandom_range(0, 999) < 4);
      id_addr   = 6'($urandom_range(0, 7));
      exe_addr  = 6'($urandom_range(0, 7));
      id_data   = 20'($urandom);
      exe_data  = 20'($urandom);
      if (id_req && exe_req && exe_addr == id_addr) exe_addr ^= 6'h1;
      hit = 0;
      foreach (mq[i]) if (mq[i].a == id_addr) hit = 1;
      if (id_req && exe_req && hit && mq.size() == QD) exe_req = 0;
      tick();
      checks++;
      if (wr_en !== e_wr_en) begin
        errors++; $display("FAIL rnd_wr_en cyc %0d got %0b want %0b", c, wr_en, e_wr_en);
      end
      if (e_wr_en) begin
        checks++;
        if ({wr_addr, wr_data} !== {e_wr_addr, e_wr_data}) begin
          errors++; $display("FAIL rnd_wr cyc %0d got %0h %0h want %0h %0h", c, wr_addr, wr_data, e_wr_addr, e_wr_data);
        end
      end
      checks++;
      if ({exe_drop, inv_done, inv_busy, q_count} !== {e_drop, e_done, e_busy, 2'(mq.size())}) begin
        errors++; $display("FAIL rnd_flags cyc %0d got d%0b n%0b b%0b q%0d want d%0b n%0b b%0b q%0d",
                           c, exe_drop, inv_done, inv_busy, q_count, e_drop, e_done, e_busy, mq.size());
      end
    end
    clr_in(); en = 1;
  endtask

  initial begin
    test_reset();
    test_single_exe();
    test_collision();
    test_overflow();
    test_cancel();
    test_sweep();
    test_en_gating_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bht_write_arbiter.md
Name: bht_write_arbiter

Overview:
- Owns the single write port of the 64-entry, 4-way branch history table (BHT).
- Arbitrates between three write sources:
  - ID-stage allocations (new branch/jump entries).
  - EXE-stage saturating-counter updates.
  - A table-invalidation sweep, e.g. for fence.i or an ISR context change.
- EXE updates that lose arbitration are buffered in a small FIFO rather than silently dropped.

Parameters:
- ENTRIES, 64, number of BHT entries; write address width is log2(ENTRIES).
- ENTRY_W, 20, BHT entry width {valid, tag[6:0], target[9:0], ctr[1:0]}.
- QDEPTH, 2, depth of the pending EXE-update FIFO (power of 2, ≥1).

Ports:
- CLK  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- en  in  1  pipeline enable; when low, all state and outputs hold and wr_en=0.
- id_req  in  1  ID allocation write request (single-cycle).
- id_addr  in  6  ID target entry index {set[3:0], way[1:0]}.
- id_data  in  20  ID entry to write.
- exe_req  in  1  EXE counter-update request (single-cycle).
- exe_addr  in  6  EXE target entry index.
- exe_data  in  20  EXE updated entry.
- inv_start  in  1  pulse: begin invalidation sweep.
- inv_busy  out  1  high while the sweep is in progress.
- inv_done  out  1  one-cycle pulse after the last sweep write.
- wr_en  out  1  BHT write strobe.
- wr_addr  out  6  BHT write index.
- wr_data  out  20  BHT write data.
- exe_drop  out  1  one-cycle pulse: EXE update discarded.
- q_count  out  2  current FIFO occupancy (0..QDEPTH).

Behaviour:
- Reset, synchronous on nrst=0:
  - State=IDLE, FIFO empty.
  - wr_en=0, wr_addr=0, wr_data=0.
  - inv_busy=0, inv_done=0, exe_drop=0, q_count=0.
  - Reset mid-sweep aborts the sweep; inv_done is not pulsed.
- All outputs are registered. A request sampled at edge N produces its wr_* at edge N+1, asserted for exactly one cycle.
- en=0: no sampling, no state change. wr_en, exe_drop and inv_done are forced 0. Requests presented while en=0 are ignored.
- FSM states: IDLE, SWEEP.
- IDLE, write priority per cycle:
  1. id_req.
  2. FIFO head.
  3. New exe_req.
- IDLE, EXE request handling:
  - id_req and exe_req together: ID writes; EXE is pushed to the FIFO.
  - FIFO non-empty, no id_req: head is popped and written. A concurrent exe_req is pushed in the same cycle; q_count is unchanged.
  - FIFO empty, exe_req only: written directly; FIFO untouched.
  - FIFO full, id_req and exe_req together: exe_req is discarded and exe_drop pulses next cycle.
  - FIFO full, exe_req without id_req: pop and push happen together; no drop.
- Stale-entry cancel: when an ID write's id_addr equals the address of a queued EXE entry, that queued entry is removed in the same cycle. The slot has been reallocated, so the counter update is obsolete. A removal does not pulse exe_drop.
- FIFO ordering: strict FIFO among surviving entries.
- IDLE, sweep start:
  - inv_start moves to SWEEP next cycle, clears the FIFO and resets the sweep counter to 0.
  - inv_start has priority over any same-cycle id_req/exe_req, which are ignored.
- SWEEP:
  - inv_busy=1.
  - Each enabled cycle writes wr_addr=counter, wr_data=0, then counter+1.
  - After address ENTRIES-1 is written, returns to IDLE and pulses inv_done for one cycle coincident with the first IDLE cycle.
  - id_req and exe_req are ignored during SWEEP (no FIFO push, no exe_drop); the table is being cleared.
  - inv_start during SWEEP is ignored.
  - en=0 pauses the sweep counter.
- Sweep duration: ENTRIES enabled cycles, plus 1 cycle start latency.
- q_count reflects occupancy after the edge's push/pop/cancel.

Test Plan:
- Reset then idle: all outputs 0. A single exe_req (addr=0x05, data=0x8A0F1) gives wr_en=1, wr_addr=0x05, wr_data=0x8A0F1 one cycle later; q_count=0.
- Collision: id_req (0x10) with exe_req (0x21) → cycle+1 writes 0x10, q_count=1; cycle+2 writes 0x21, q_count=0.
- Overflow: 3 consecutive cycles of id_req+exe_req → third EXE dropped. exe_drop pulses once, q_count=2; the two queued EXE writes then drain in order.
- Cancel: queue EXE at 0x0C, then id_req at 0x0C → ID write to 0x0C, q_count=0, no later EXE write to 0x0C, exe_drop=0.
- Sweep: inv_start with 1 queued entry → FIFO cleared; 64 writes addr 0..63, data 0, inv_busy high throughout, inv_done pulses once. Requests during the sweep produce no writes.
- en gating and reset: deassert en for 3 cycles mid-sweep → counter holds, no writes. Assert nrst=0 mid-sweep → IDLE, inv_busy=0, no inv_done.
